// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator with RMW for sub-word stores and load extension
// Optional misalignment faulting is compiled in with LSU_ALIGN_CHECK_EN.
module lsu_mem_master #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_len,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_we,
  output logic [1:0]        mem_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state, state_nxt, first_st;
  logic                accept;
  logic [1:0]          len_in;
  logic                fault_in;
  logic                we_q, sgn_q, fault_q;
  logic [1:0]          len_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:8]         cap_q;
  logic [CNT_W-1:0]    cnt;
  logic [31:0]         load_fmt;

  assign req_ready  = (state == IDLE) || (state == RESP);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign resp_fault = resp_valid && fault_q;

  // The reserved length encoding behaves as a word access unless it faults.
  assign len_in = (req_len == 2'b11) ? LEN_WORD : req_len;

`ifdef LSU_ALIGN_CHECK_EN
  assign fault_in = (req_len == 2'b11) ||
                    ((req_len == LEN_HALF) && req_addr[0]) ||
                    ((req_len == LEN_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign fault_in = 1'b0;
`endif

  always_comb begin
    first_st = READ;
    if (fault_in)
      first_st = RESP;
    else if (req_we && (len_in == LEN_WORD))
      first_st = WRITE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = first_st;
      READ:    if (cnt == '0) state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = accept ? first_st : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_fmt = mem_rdata;
    case (len_q)
      LEN_BYTE: load_fmt = {{24{sgn_q & mem_rdata[7]}}, mem_rdata[7:0]};
      LEN_HALF: load_fmt = {{16{sgn_q & mem_rdata[15]}}, mem_rdata[15:0]};
      default:  load_fmt = mem_rdata;
    endcase
  end

  // The final READ edge either completes a load or captures the word an RMW merges into.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      fault_q    <= 1'b0;
      len_q      <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      cap_q      <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      sgn_q   <= req_signed;
      fault_q <= fault_in;
      len_q   <= len_in;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      cnt     <= CNT_W'(MEM_LAT - 1);
    end else if (state == READ) begin
      if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
      else if (we_q)
        cap_q <= mem_rdata[31:8];
      else
        resp_rdata <= load_fmt;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_len   = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      READ: begin
        mem_addr = addr_q;
        mem_len  = we_q ? LEN_WORD : len_q;
      end
      WRITE: begin
        mem_we   = 1'b1;
        mem_len  = LEN_WORD;
        mem_addr = addr_q;
        case (len_q)
          LEN_BYTE: mem_wdata = {cap_q[31:8], wdata_q[7:0]};
          LEN_HALF: mem_wdata = {cap_q[31:16], wdata_q[15:0]};
          default:  mem_wdata = wdata_q;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - scoreboard bench for lsu_mem_master against a byte-level memory model
// Honours LSU_ALIGN_CHECK_EN when the design is built with it.
module tb_lsu_mem_master;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_len;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  lsu_mem_master #(.MEM_LAT(MEM_LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_len(req_len), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: 256 bytes, little-endian, decodes low address bits.
  logic [7:0] dmem [0:255];
  logic [7:0] ma;
  assign ma = mem_addr[7:0];
  assign mem_rdata = {dmem[ma + 8'd3], dmem[ma + 8'd2], dmem[ma + 8'd1], dmem[ma]};
  always @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++) dmem[ma + 8'(i)] <= mem_wdata[8*i +: 8];

  typedef struct {
    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          wr;
    int          acc;
    logic [31:0] addr;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [0:255];
  logic [31:0] last_rd;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          wcount = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] mon_rdata = '0;
  logic        mon_fault = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: accesses are byte-granular reads/writes of 1, 2 or 4 bytes.
  task automatic model(input logic we, input logic [1:0] len, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input int acc);
    exp_t e;
    int nb;
    logic [31:0] w, mask;
    logic flt;
`ifdef LSU_ALIGN_CHECK_EN
    flt = (len == 2'b11) || (len == 2'b01 && addr[0]) || (len == 2'b10 && addr[1:0] != 0);
`else
    flt = 1'b0;
`endif
    nb = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    e.flt = flt; e.acc = acc; e.addr = addr; e.wr = 0; e.rd = last_rd;
    if (flt) begin
      e.lat = 1;
    end else if (!we) begin
      w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[8'(addr + 32'(i))];
      mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
      e.rd = w & mask;
      if (sg && nb < 4 && w[8*nb-1]) e.rd = e.rd | ~mask;
      last_rd = e.rd;
      e.lat = MEM_LAT + 1;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[8'(addr + 32'(i))] = wd[8*i +: 8];
      e.wr  = 1;
      e.lat = (nb == 4) ? 2 : MEM_LAT + 2;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        wcount++;
        last_wdata = mem_wdata;
        chk("wr_len", {30'd0, mem_len}, 32'd2);
        if (q.size() != 0) chk("wr_addr", mem_addr, q[0].addr);
      end
      if (req_ready)
        chk("bus_idle", {mem_we, mem_len, mem_addr | mem_wdata}, 35'd0);
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rd);
          chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.flt});
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("write_count", 32'(wcount), 32'(e.wr));
          mon_rdata = resp_rdata;
          mon_fault = resp_fault;
          wcount = 0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] len, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    req_we = we; req_len = len; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    model(we, len, sg, addr, wd, acc);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    logic [31:0] saved;
    logic [31:0] t_addr [5] = '{32'h20, 32'h20, 32'h20, 32'h21, 32'h21};
    logic [1:0]  t_len  [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic        t_sg   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_exp  [5] = '{32'h1, 32'hFFFF8001, 32'h8001, 32'hFFFFFF80, 32'h80};

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_len = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; last_rd = '0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      dmem[i] <= b;
      ref_mem[i] = b;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {30'd0, resp_valid, resp_fault}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, a0); idle(); drain();
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, a0); idle(); drain();
    chk("lw_after_sw", mon_rdata, 32'hDEADBEEF);
    issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055, a0); idle(); drain();
    chk("sb_rmw_wdata", last_wdata, 32'hDEADBE55);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, a0); idle(); drain();
    chk("lw_after_sb", mon_rdata, 32'hDEADBE55);

    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h12348001, a0); idle(); drain();
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, t_len[i], t_sg[i], t_addr[i], 32'h0, a0); idle(); drain();
      chk($sformatf("ext_load_%0d", i), mon_rdata, t_exp[i]);
    end

    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, a0);
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, a1);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, a2);
    idle(); drain();
    chk("b2b_accept1", 32'(a1 - a0), 32'(MEM_LAT + 1));
    chk("b2b_accept2", 32'(a2 - a1), 32'd2);
    chk("b2b_last", mon_rdata, 32'hCAFEF00D);

    saved = {dmem[8'h33], dmem[8'h32], dmem[8'h31], dmem[8'h30]};
    wcount = 0;
    @(negedge clk);
    req_we = 1'b1; req_len = 2'b01; req_signed = 1'b0; req_addr = 32'h30;
    req_wdata = 32'h0000ABCD; req_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("inrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("inrst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    last_rd = '0;
    repeat (MEM_LAT + 4) @(negedge clk);
    #1;
    chk("abort_no_write", 32'(wcount), 32'd0);
    chk("abort_mem", {dmem[8'h33], dmem[8'h32], dmem[8'h31], dmem[8'h30]}, saved);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rdata", resp_rdata, 32'd0);

    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, a0); idle(); drain();
`ifdef LSU_ALIGN_CHECK_EN
    chk("misaligned_fault", {31'd0, mon_fault}, 32'd1);
`else
    chk("misaligned_fault", {31'd0, mon_fault}, 32'd0);
`endif

    for (int r = 0; r < 300; r++) begin
      int gap;
      issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, a0);
      gap = int'($urandom_range(0, 2));
      if (gap != 0) begin
        idle();
        repeat (gap - 1) @(negedge clk);
      end
    end
    idle();
    drain();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++)
      chk($sformatf("mem_byte_%0d", i), {24'd0, dmem[i]}, {24'd0, ref_mem[i]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the MEM stage and the byte-addressed data memory port.
- The memory port has two properties this block is built around:
  - It returns little-endian 32-bit reads combinationally.
  - Every write updates all 4 bytes at addr..addr+3.
- The block therefore performs read-modify-write for byte/half stores and sign/zero-extends load data.
- Pipeline handshake is valid/ready; one request is in flight at a time.

Parameters:
- MEM_LAT, 1: read cycles per memory read (≥1); mem_rdata is sampled on the last READ edge.
- ADDR_W, 32: width of address ports.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_len  in  2  access size; encodings are the shared `byte/`half/`word macros
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; the low byte/half is used for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  formatted load data
- resp_fault  out  1  misalignment fault, qualified by resp_valid
- mem_we  out  1  memory write enable
- mem_len  out  2  memory access size
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- req_ready = 1 in IDLE and RESP only. A request is accepted on a clk edge with req_valid && req_ready; all req_* fields are latched at that edge.
- Transitions on accept:
  - Load: → READ.
  - Word store: → WRITE.
  - Byte/half store: → READ (RMW).
- READ:
  - Holds for MEM_LAT cycles; a down-counter is loaded with MEM_LAT-1 at accept.
  - mem_we = 0; mem_addr = latched address.
  - mem_len = latched len for loads, `word for RMW.
  - On the final READ edge, mem_rdata is captured.
  - Load → RESP. RMW → WRITE.
- WRITE:
  - Exactly one cycle: mem_we = 1, mem_len = `word, mem_addr = latched address.
  - mem_wdata:
    - Word store: latched wdata.
    - Byte store: {captured[31:8], wdata[7:0]}.
    - Half store: {captured[31:16], wdata[15:0]}.
  - → RESP.
- RESP:
  - resp_valid = 1 for one cycle.
  - Accept of a new request goes directly to its first state; otherwise → IDLE.
- Load formatting:
  - Byte: ext(rdata[7:0]).
  - Half: ext(rdata[15:0]).
  - Word: unchanged.
  - ext is sign or zero extension per req_signed.
- resp_rdata updates only when a load completes and holds otherwise. Stores leave it unchanged.
- Latency from accept edge to resp_valid cycle:
  - Word store: 2.
  - Load: MEM_LAT+1.
  - Sub-word store: MEM_LAT+2.
- Back-to-back requests: sustained issue with no idle bubble.
- In IDLE and RESP: mem_we = 0 and mem_addr/mem_len/mem_wdata = 0.
- Reset (asynchronous, rst low):
  - State → IDLE; counter → 0.
  - resp_valid, resp_fault, resp_rdata, latched fields → 0.
  - mem_we drops immediately.
  - A reset during READ of an RMW aborts it with no write. No response is ever issued for the aborted request.
- req_len = 2'b11 is treated as `word, unless the optional feature below is compiled in.
- Address wrap is not handled; the memory decodes the low address bits.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - A half with addr[0] = 1, a word with addr[1:0] ≠ 0, or len = 2'b11 is a fault.
  - A faulting request goes IDLE/RESP → RESP directly, with no READ/WRITE and mem_we never asserted.
  - resp_fault = 1 with resp_valid; resp_rdata is unchanged.
- Undefined: resp_fault is tied 0 and all addresses are accessed.

Test Plan:
- Word store 0x10, data 0xDEADBEEF → mem_we high exactly 1 cycle with mem_len=`word, mem_addr=0x10; resp_valid 2 cycles after accept. A following lw 0x10 returns 0xDEADBEEF.
- sb 0x10, data 0x00000055 over 0xDEADBEEF → READ (MEM_LAT cycles) then WRITE with mem_wdata 0xDEADBE55; resp_valid at MEM_LAT+2. A following lw returns 0xDEADBE55.
- Memory word 0x12348001 at 0x20:
  - lb signed → 0x00000001.
  - lh signed → 0xFFFF8001.
  - lhu → 0x00008001.
  - lb signed at 0x21 → 0xFFFFFF80.
  - lbu at 0x21 → 0x00000080.
- req_valid held through RESP with lw, sw, lw → each accepted in the RESP cycle of the previous request; exactly one resp_valid pulse per request; no IDLE cycles between requests.
- rst pulsed low during READ of sh 0x30 → mem_we never asserts; memory at 0x30 is unchanged; state IDLE and req_ready=1 after release; no resp_valid.
- With LSU_ALIGN_CHECK_EN: lw 0x12 → resp_valid with resp_fault=1 the cycle after accept; mem_we=0 throughout. Without the macro, the same lw reads bytes 0x12..0x15 with resp_fault=0.
